reg_dump_sequencer: RTL and testbench
=====================================

REG_DUMP_SEQUENCER -- requirements
Module: reg_dump_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, width of one register-file word.
REQ-002 Parameter ADDR_W, default 5, width of register index / read address.
REQ-003 Parameter NUM_REGS, default 13, registers dumped per snapshot (legal range 1..2^ADDR_W).
REQ-004 Parameter END_COUNT, default 25, counted run cycles before a dump (legal range 1..2^32-1).
REQ-005 Parameter PERIODIC, default 0, 0 = one-shot then halt, 1 = re-arm after every dump.
REQ-006 clk_i  input  1  single clock; all state changes on rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-low.
REQ-008 run_i  input  1  CPU running; qualifies the cycle counter.
REQ-009 clear_i  input  1  synchronous restart to COUNT with counter zeroed.
REQ-010 rf_addr_o  output  ADDR_W  register-file read address.
REQ-011 rf_data_i  input  DATA_W  combinational read data for rf_addr_o.
REQ-012 freeze_o  output  1  stalls the CPU while a dump is in progress.
REQ-013 dump_valid_o / dump_ready_i  output / input  1 / 1  dump stream handshake.
REQ-014 dump_idx_o  output  ADDR_W  register index of current beat.
REQ-015 dump_data_o  output  DATA_W  register value of current beat.
REQ-016 dump_last_o  output  1  high on beat with index NUM_REGS-1.
REQ-017 done_o  output  1  one-cycle pulse after last beat accepted.
REQ-018 cycle_cnt_o  output  32  current run-cycle count.

Function
REQ-019 The FSM SHALL have states COUNT, LOAD, SEND, DONE, HALT.
REQ-020 In COUNT, cycle_cnt SHALL increment by 1 on each edge with run_i=1 and hold when run_i=0.
REQ-021 When the incremented count equals END_COUNT, the FSM SHALL enter LOAD with index 0 on that same edge.
REQ-022 freeze_o SHALL be high in LOAD, SEND and DONE, low in COUNT and HALT.
REQ-023 rf_addr_o SHALL equal the index register in every state.
REQ-024 In LOAD, dump_data_o SHALL capture rf_data_i and dump_idx_o the index; next state SEND.
REQ-025 In SEND, dump_valid_o SHALL be 1; dump_data_o, dump_idx_o, dump_last_o SHALL stay stable until dump_valid_o & dump_ready_i.
REQ-026 On handshake with index < NUM_REGS-1, index SHALL increment and the FSM SHALL return to LOAD (max throughput one beat per 2 cycles).
REQ-027 On handshake with index = NUM_REGS-1, the FSM SHALL enter DONE; done_o SHALL be 1 for exactly that one DONE cycle.
REQ-028 From DONE, PERIODIC=1 SHALL go to COUNT with cycle_cnt=0 and index=0; PERIODIC=0 SHALL go to HALT.
REQ-029 HALT SHALL hold cycle_cnt and ignore run_i and dump_ready_i until clear_i.
REQ-030 clear_i=1 in any state SHALL, on the next edge, force COUNT, cycle_cnt=0, index=0, dump_valid_o=0; clear_i outranks a simultaneous handshake.
REQ-031 run_i SHALL be ignored outside COUNT; dump_ready_i SHALL be ignored outside SEND.
REQ-032 dump_valid_o SHALL never be high outside SEND.

Reset
REQ-033 rst_i=0 SHALL immediately force state COUNT, cycle_cnt_o=0, index=0, rf_addr_o=0, dump_idx_o=0, dump_data_o=0, dump_valid_o=0, dump_last_o=0, done_o=0, freeze_o=0, regardless of clk_i.
REQ-034 Reset asserted mid-dump SHALL abort the dump with no further beats; after release counting restarts from 0.

Verification
REQ-035 Defaults, run_i=1 constant, ready=1, RF[i]=i*3 -> freeze_o rises after 25th edge; 13 beats idx 0..12, data 0..36, last on idx 12; done_o one pulse; HALT, freeze_o=0.
REQ-036 run_i low for 5 cycles during COUNT -> dump starts 5 cycles later than REQ-035; cycle_cnt_o holds during gap.
REQ-037 ready low 4 cycles while beat idx 3 valid -> valid stays 1, idx=3, data unchanged; idx 4 appears in LOAD->SEND after ready.
REQ-038 PERIODIC=1, END_COUNT=4, NUM_REGS=2 -> repeating pattern: 4 count cycles, 2 beats, done_o pulse, count from 0 again.
REQ-039 rst_i low during beat idx 6 -> valid and freeze_o drop without clock edge; after release no beat until 25 new run cycles.
REQ-040 clear_i with ready=1 on beat idx 12 -> no done_o, state COUNT, cycle_cnt_o=0.

Source files
------------

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
//
// Counts CPU run cycles. Once END_COUNT of them have been seen, the CPU is
// frozen and the first NUM_REGS register-file words are streamed out over a
// valid/ready interface, one beat per LOAD/SEND pair. After the last beat is
// accepted, done_o pulses for one cycle. The block then either halts
// (PERIODIC=0) or re-arms the counter (PERIODIC=1).
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-low reset
//   run_i               CPU running; qualifies the cycle counter in COUNT
//   clear_i             synchronous restart into COUNT with counter/index zeroed
//   rf_addr_o/rf_data_i register-file read port (combinational read data)
//   freeze_o            CPU stall while a dump is in progress
//   dump_valid_o/ready  dump beat handshake
//   dump_idx_o/data_o   index and value of the current beat
//   dump_last_o         marks the beat with index NUM_REGS-1
//   done_o              one-cycle pulse after the last beat is accepted
//   cycle_cnt_o         current run-cycle count
module reg_dump_sequencer #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 5,
    parameter int          NUM_REGS  = 13,
    parameter logic [31:0] END_COUNT = 32'd25,
    parameter bit          PERIODIC  = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              freeze_o,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              done_o,
    output logic [31:0]       cycle_cnt_o
);

    typedef enum logic [2:0] {
        S_COUNT,
        S_LOAD,
        S_SEND,
        S_DONE,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state, state_n;
    logic [31:0]         cnt, cnt_n, cnt_inc;
    logic [ADDR_W-1:0]   idx, idx_n;
    logic [ADDR_W-1:0]   didx, didx_n;
    logic [DATA_W-1:0]   data, data_n;
    logic                last, last_n;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_COUNT;
            cnt   <= '0;
            idx   <= '0;
            didx  <= '0;
            data  <= '0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            didx  <= didx_n;
            data  <= data_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        didx_n  = didx;
        data_n  = data;
        last_n  = last;
        cnt_inc = cnt + 32'd1;

        case (state)
            S_COUNT: begin
                if (run_i) begin
                    cnt_n = cnt_inc;
                    // Trigger on the edge that makes the count reach END_COUNT.
                    if (cnt_inc == END_COUNT) begin
                        state_n = S_LOAD;
                        idx_n   = '0;
                    end
                end
            end
            S_LOAD: begin
                // Latch the beat so the stream stays stable while stalled,
                // independent of later register-file changes.
                data_n  = rf_data_i;
                didx_n  = idx;
                last_n  = (idx == LAST_IDX);
                state_n = S_SEND;
            end
            S_SEND: begin
                if (dump_ready_i) begin
                    if (idx == LAST_IDX) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx + ADDR_W'(1);
                        state_n = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (PERIODIC) begin
                    state_n = S_COUNT;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    state_n = S_HALT;
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_COUNT;
            end
        endcase

        // Restart wins over everything, including a same-cycle handshake.
        if (clear_i) begin
            state_n = S_COUNT;
            cnt_n   = '0;
            idx_n   = '0;
        end
    end

    assign rf_addr_o    = idx;
    assign freeze_o     = (state == S_LOAD) || (state == S_SEND) || (state == S_DONE);
    assign dump_valid_o = (state == S_SEND);
    assign done_o       = (state == S_DONE);
    assign dump_idx_o   = didx;
    assign dump_data_o  = data;
    assign dump_last_o  = last;
    assign cycle_cnt_o  = cnt;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Testbench for reg_dump_sequencer: a default-parameter instance checked
// against a cycle-level behavioural model under directed and random stimulus,
// plus a periodic instance (END_COUNT=4, NUM_REGS=2) checked from a vector table.
module tb_reg_dump_sequencer;

    localparam int END = 25;
    localparam int N   = 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, ready, clr;
    logic [4:0]  rf_addr, didx;
    logic [31:0] rf_data, ddata, cnt;
    logic        freeze, valid, dlast, done;
    logic [31:0] rf [32];

    logic        p_run, p_ready, p_clear;
    logic [4:0]  p_addr, p_idx;
    logic [31:0] p_rf_data, p_data, p_cnt;
    logic        p_freeze, p_valid, p_last, p_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign rf_data   = rf[rf_addr];
    assign p_rf_data = 32'(p_addr) * 32'd3;

    reg_dump_sequencer dut (
        .clk_i(clk), .rst_i(rst_n), .run_i(run), .clear_i(clr),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data), .freeze_o(freeze),
        .dump_valid_o(valid), .dump_ready_i(ready), .dump_idx_o(didx),
        .dump_data_o(ddata), .dump_last_o(dlast), .done_o(done),
        .cycle_cnt_o(cnt)
    );

    reg_dump_sequencer #(.NUM_REGS(2), .END_COUNT(32'd4), .PERIODIC(1'b1)) pdut (
        .clk_i(clk), .rst_i(rst_n), .run_i(p_run), .clear_i(p_clear),
        .rf_addr_o(p_addr), .rf_data_i(p_rf_data), .freeze_o(p_freeze),
        .dump_valid_o(p_valid), .dump_ready_i(p_ready), .dump_idx_o(p_idx),
        .dump_data_o(p_data), .dump_last_o(p_last), .done_o(p_done),
        .cycle_cnt_o(p_cnt)
    );

    // ---------------- behavioural model (default instance) ----------------
    // m_runs: counted run cycles; m_beat: beat being delivered; m_fetch: the
    // cycle spent reading the register file before a beat is offered.
    int          m_runs, m_beat;
    bit          m_dumping, m_fetch, m_done, m_halted;
    logic [31:0] m_data;

    task automatic model_reset();
        m_runs = 0; m_beat = 0; m_dumping = 0; m_fetch = 0;
        m_done = 0; m_halted = 0; m_data = '0;
    endtask

    task automatic model_step(input bit r, input bit rd, input bit c);
        if (c) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0; m_halted = 1;
        end else if (m_dumping) begin
            if (m_fetch) begin
                m_fetch = 0; m_data = rf[m_beat];
            end else if (rd) begin
                if (m_beat == N - 1) begin
                    m_dumping = 0; m_done = 1;
                end else begin
                    m_beat++; m_fetch = 1;
                end
            end
        end else if (!m_halted && r) begin
            m_runs++;
            if (m_runs == END) begin
                m_dumping = 1; m_beat = 0; m_fetch = 1;
            end
        end
    endtask

    task automatic check_obs();
        bit ok, e_frz, e_vld;
        e_frz = m_dumping || m_done;
        e_vld = m_dumping && !m_fetch;
        ok = (freeze === e_frz) && (valid === e_vld) && (done === m_done);
        if (e_vld)
            ok &= (didx === 5'(m_beat)) && (ddata === m_data) && (dlast === (m_beat == N - 1));
        if (m_dumping)
            ok &= (rf_addr === 5'(m_beat));
        if (!e_frz)
            ok &= (cnt === 32'(m_runs));
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL model t=%0t got frz=%b vld=%b done=%b idx=%0d data=%h last=%b cnt=%0d | exp frz=%b vld=%b done=%b idx=%0d data=%h cnt=%0d",
                     $time, freeze, valid, done, didx, ddata, dlast, cnt,
                     e_frz, e_vld, m_done, m_beat, m_data, m_runs);
        end
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input bit c);
        run = r; ready = rd; clr = c;
        @(posedge clk);
        model_step(r, rd, c);
        @(negedge clk);
        check_obs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 0; ready = 0; clr = 0;
        p_run = 0; p_ready = 0; p_clear = 0;
        @(negedge clk); @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic run_to_beat(input int k);
        int n = 0;
        while (!(m_dumping && !m_fetch && m_beat == k) && n < 200) begin
            cyc(1, 1, 0); n++;
        end
        chk("reach_beat", (valid && didx == 5'(k)) ? 1 : 0, 1);
    endtask

    // ---------------- periodic vector table ----------------
    typedef struct {
        bit run, ready, frz, vld, last, dn;
        int idx, cnt;
        bit chk_cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, ff, nb, nl, nd;
        logic [31:0] saved;

        //        run rdy frz vld lst dn idx cnt chk
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 2, 1};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 3, 1};
        tbl[3]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 1, 1, 0, 1, 0, 0};
        tbl[7]  = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{1, 1, 0, 0, 0, 0, 0, 2, 1};
        tbl[12] = '{1, 1, 0, 0, 0, 0, 0, 3, 1};
        tbl[13] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 1, 1, 1, 0, 1, 0, 0};
        tbl[18] = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        tbl[19] = '{1, 1, 0, 0, 0, 0, 0, 0, 1};

        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'd3;

        // Reset state, observed while reset is held.
        rst_n = 1'b0; run = 0; ready = 0; clr = 0;
        p_run = 0; p_ready = 0; p_clear = 0;
        #3;
        chk("rst_freeze", freeze, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_idx", didx, 0);
        chk("rst_data", ddata, 0);
        chk("rst_last", dlast, 0);

        // Basic one-shot dump, run and ready held high.
        do_reset();
        e = 0; ff = -1; nb = 0; nl = 0; nd = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1, 1, 0); e++;
            if (freeze && ff < 0) ff = e;
            if (valid) nb++;
            if (valid && dlast) nl++;
            if (done) nd++;
        end
        chk("first_freeze_edge", ff, END);
        chk("beat_count", nb, N);
        chk("last_count", nl, 1);
        chk("done_pulses", nd, 1);
        chk("halt_freeze", freeze, 0);
        chk("halt_cnt", cnt, END);

        // Run gap of 5 cycles delays the dump by 5.
        do_reset();
        e = 0; ff = -1;
        for (int i = 0; i < 10; i++) begin cyc(1, 1, 0); e++; end
        for (int i = 0; i < 5; i++) begin cyc(0, 1, 0); e++; end
        chk("gap_hold", cnt, 10);
        while (!freeze && e < 100) begin cyc(1, 1, 0); e++; end
        chk("gap_freeze_edge", e, END + 5);

        // Stall on beat 3; register file changes underneath the held beat.
        do_reset();
        run_to_beat(3);
        saved = ddata;
        rf[3] = ~rf[3];
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0);
            chk("stall_valid", valid, 1);
            chk("stall_idx", didx, 3);
            chk("stall_data", ddata, saved);
        end
        cyc(1, 1, 0);
        chk("post_stall_load", valid, 0);
        cyc(1, 1, 0);
        chk("beat4_valid", valid, 1);
        chk("beat4_idx", didx, 4);
        rf[3] = 32'd9;

        // Asynchronous reset during beat 6.
        do_reset();
        run_to_beat(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_freeze", freeze, 0);
        chk("arst_addr", rf_addr, 0);
        chk("arst_idx", didx, 0);
        chk("arst_data", ddata, 0);
        chk("arst_cnt", cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        while (!freeze && e < 100) begin cyc(1, 1, 0); e++; end
        chk("arst_restart_edge", e, END);

        // Clear coinciding with acceptance of the last beat.
        do_reset();
        run_to_beat(N - 1);
        cyc(1, 1, 1);
        chk("clr_done", done, 0);
        chk("clr_freeze", freeze, 0);
        chk("clr_valid", valid, 0);
        chk("clr_cnt", cnt, 0);
        cyc(1, 1, 0);
        chk("clr_no_late_done", done, 0);
        chk("clr_counting", cnt, 1);

        // Periodic instance from the vector table.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bit ok;
            p_run = tbl[i].run; p_ready = tbl[i].ready;
            @(posedge clk);
            @(negedge clk);
            ok = (p_freeze === tbl[i].frz) && (p_valid === tbl[i].vld) && (p_done === tbl[i].dn);
            if (tbl[i].vld)
                ok &= (p_idx === 5'(tbl[i].idx)) && (p_last === tbl[i].last) &&
                      (p_data === 32'(tbl[i].idx * 3));
            if (tbl[i].chk_cnt)
                ok &= (p_cnt === 32'(tbl[i].cnt));
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL periodic row %0d: got frz=%b vld=%b done=%b idx=%0d last=%b data=%0d cnt=%0d exp frz=%b vld=%b done=%b idx=%0d cnt=%0d",
                         i, p_freeze, p_valid, p_done, p_idx, p_last, p_data, p_cnt,
                         tbl[i].frz, tbl[i].vld, tbl[i].dn, tbl[i].idx, tbl[i].cnt);
            end
        end
        p_run = 0; p_ready = 0;

        // Random traffic against the model, with occasional clears.
        do_reset();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 1500; i++) begin
            bit r, rd, c;
            r  = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 6);
            c  = ($urandom_range(0, 79) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) rf[$urandom_range(0, 31)] = $urandom;
            cyc(r, rd, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
